// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_pkg
//  Brief    : Shared types and defaults for the IFU/LSU memory-port arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package mem_arbiter_pkg;

    // Arbiter transaction phases
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // Which requester owns the in-flight transaction
    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    localparam int DEFAULT_ADDR_W  = 32;
    localparam int DEFAULT_DATA_W  = 32;
    localparam int DEFAULT_MASK_W  = 8;
    localparam int DEFAULT_TIMEOUT = 255;

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_if
//  Brief    : Bundles the IFU, LSU and memory-side handshake signals.
//             slave  : the arbiter's view of the bundle.
//             master : the surrounding core / memory wrapper view.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MASK_W = 8
);
    // IFU side
    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_resp_valid;
    logic [DATA_W-1:0] ifu_rdata;
    logic              ifu_resp_err;
    // LSU side
    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_addr;
    logic              lsu_wen;
    logic [DATA_W-1:0] lsu_wdata;
    logic [MASK_W-1:0] lsu_wmask;
    logic              lsu_resp_valid;
    logic [DATA_W-1:0] lsu_rdata;
    logic              lsu_resp_err;
    // Memory side
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );

endinterface : mem_arbiter_if
`default_nettype wire

// File: rtl/mem_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter2
//  Brief    : Two-way round-robin grant. A lone requester always wins; on a
//             conflict the requester that was not granted last time wins.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic   i_ifu_valid,
    input  logic   i_lsu_valid,
    input  owner_e i_last_grant,
    output logic   o_gnt_valid,
    output owner_e o_gnt_owner
);

    // Pick the winner from the two valids and the previous grant
    always_comb begin
        o_gnt_valid = i_ifu_valid | i_lsu_valid;
        o_gnt_owner = OWN_IFU;
        if (i_ifu_valid && i_lsu_valid) begin
            o_gnt_owner = (i_last_grant == OWN_IFU) ? OWN_LSU : OWN_IFU;
        end else if (i_lsu_valid) begin
            o_gnt_owner = OWN_LSU;
        end
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Brief    : Shares one memory port between instruction fetch and load/store.
//             One transaction in flight at a time: IDLE grants, REQ holds the
//             request until memory accepts, WAIT waits for the response under
//             a timeout, RESP returns a one-cycle strobe to the owner.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int MASK_W  = DEFAULT_MASK_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT   // must be >= 1
)
(
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    // Counter wide enough to hold TIMEOUT-1 even for TIMEOUT == 1
    localparam int                CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e              state_q,        state_d;
    owner_e              owner_q,        owner_d;
    owner_e              last_grant_q,   last_grant_d;
    logic [CNT_W-1:0]    cnt_q,          cnt_d;

    logic                mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_W-1:0]   mem_addr_q,     mem_addr_d;
    logic                mem_wen_q,      mem_wen_d;
    logic [DATA_W-1:0]   mem_wdata_q,    mem_wdata_d;
    logic [MASK_W-1:0]   mem_wmask_q,    mem_wmask_d;

    logic                ifu_resp_valid_q, ifu_resp_valid_d;
    logic [DATA_W-1:0]   ifu_rdata_q,      ifu_rdata_d;
    logic                ifu_resp_err_q,   ifu_resp_err_d;
    logic                lsu_resp_valid_q, lsu_resp_valid_d;
    logic [DATA_W-1:0]   lsu_rdata_q,      lsu_rdata_d;
    logic                lsu_resp_err_q,   lsu_resp_err_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                w_gnt_valid;
    owner_e              w_gnt_owner;
    logic                w_ifu_req_ready;
    logic                w_lsu_req_ready;
    logic                w_done;
    logic                w_err;
    logic [DATA_W-1:0]   w_data;

    rr_arbiter2 u_rr_arbiter2 (
        .i_ifu_valid  (bus.ifu_req_valid),
        .i_lsu_valid  (bus.lsu_req_valid),
        .i_last_grant (last_grant_q),
        .o_gnt_valid  (w_gnt_valid),
        .o_gnt_owner  (w_gnt_owner)
    );

    // Next-state and next-output logic for the whole transaction flow
    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        last_grant_d     = last_grant_q;
        cnt_d            = cnt_q;
        mem_req_valid_d  = mem_req_valid_q;
        mem_addr_d       = mem_addr_q;
        mem_wen_d        = mem_wen_q;
        mem_wdata_d      = mem_wdata_q;
        mem_wmask_d      = mem_wmask_q;
        ifu_resp_valid_d = ifu_resp_valid_q;
        ifu_rdata_d      = ifu_rdata_q;
        ifu_resp_err_d   = ifu_resp_err_q;
        lsu_resp_valid_d = lsu_resp_valid_q;
        lsu_rdata_d      = lsu_rdata_q;
        lsu_resp_err_d   = lsu_resp_err_q;
        w_ifu_req_ready  = 1'b0;
        w_lsu_req_ready  = 1'b0;
        w_done           = 1'b0;
        w_err            = 1'b0;
        w_data           = '0;

        case (state_q)
            ST_IDLE: begin
                // Ready goes only to the winner, so a grant is a handshake
                if (w_gnt_valid) begin
                    owner_d         = w_gnt_owner;
                    last_grant_d    = w_gnt_owner;
                    mem_req_valid_d = 1'b1;
                    state_d         = ST_REQ;
                    if (w_gnt_owner == OWN_LSU) begin
                        w_lsu_req_ready = 1'b1;
                        mem_addr_d      = bus.lsu_addr;
                        mem_wen_d       = bus.lsu_wen;
                        mem_wdata_d     = bus.lsu_wdata;
                        mem_wmask_d     = bus.lsu_wen ? bus.lsu_wmask : '0;
                    end else begin
                        // Fetches are always plain reads
                        w_ifu_req_ready = 1'b1;
                        mem_addr_d      = bus.ifu_addr;
                        mem_wen_d       = 1'b0;
                        mem_wdata_d     = '0;
                        mem_wmask_d     = '0;
                    end
                end
            end

            ST_REQ: begin
                // Request fields stay frozen until memory takes them
                if (bus.mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    cnt_d           = '0;
                    state_d         = ST_WAIT;
                end
            end

            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A real response beats a timeout landing on the same cycle
                if (bus.mem_resp_valid) begin
                    w_done = 1'b1;
                    w_err  = 1'b0;
                    w_data = mem_wen_q ? '0 : bus.mem_rdata;
                end else if (cnt_q == TO_LAST) begin
                    w_done = 1'b1;
                    w_err  = 1'b1;
                    w_data = '0;
                end
                if (w_done) begin
                    state_d = ST_RESP;
                    if (owner_q == OWN_IFU) begin
                        ifu_resp_valid_d = 1'b1;
                        ifu_rdata_d      = w_data;
                        ifu_resp_err_d   = w_err;
                    end else begin
                        lsu_resp_valid_d = 1'b1;
                        lsu_rdata_d      = w_data;
                        lsu_resp_err_d   = w_err;
                    end
                end
            end

            ST_RESP: begin
                // Single-cycle strobe; no new grant until back in IDLE
                ifu_resp_valid_d = 1'b0;
                ifu_rdata_d      = '0;
                ifu_resp_err_d   = 1'b0;
                lsu_resp_valid_d = 1'b0;
                lsu_rdata_d      = '0;
                lsu_resp_err_d   = 1'b0;
                cnt_d            = '0;
                state_d          = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register all state and outputs; reset aborts any transaction silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            owner_q          <= OWN_IFU;
            last_grant_q     <= OWN_IFU;
            cnt_q            <= '0;
            mem_req_valid_q  <= 1'b0;
            mem_addr_q       <= '0;
            mem_wen_q        <= 1'b0;
            mem_wdata_q      <= '0;
            mem_wmask_q      <= '0;
            ifu_resp_valid_q <= 1'b0;
            ifu_rdata_q      <= '0;
            ifu_resp_err_q   <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
            lsu_rdata_q      <= '0;
            lsu_resp_err_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            owner_q          <= owner_d;
            last_grant_q     <= last_grant_d;
            cnt_q            <= cnt_d;
            mem_req_valid_q  <= mem_req_valid_d;
            mem_addr_q       <= mem_addr_d;
            mem_wen_q        <= mem_wen_d;
            mem_wdata_q      <= mem_wdata_d;
            mem_wmask_q      <= mem_wmask_d;
            ifu_resp_valid_q <= ifu_resp_valid_d;
            ifu_rdata_q      <= ifu_rdata_d;
            ifu_resp_err_q   <= ifu_resp_err_d;
            lsu_resp_valid_q <= lsu_resp_valid_d;
            lsu_rdata_q      <= lsu_rdata_d;
            lsu_resp_err_q   <= lsu_resp_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign bus.ifu_req_ready  = w_ifu_req_ready;
    assign bus.lsu_req_ready  = w_lsu_req_ready;
    assign bus.ifu_resp_valid = ifu_resp_valid_q;
    assign bus.ifu_rdata      = ifu_rdata_q;
    assign bus.ifu_resp_err   = ifu_resp_err_q;
    assign bus.lsu_resp_valid = lsu_resp_valid_q;
    assign bus.lsu_rdata      = lsu_rdata_q;
    assign bus.lsu_resp_err   = lsu_resp_err_q;
    assign bus.mem_req_valid  = mem_req_valid_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_wen        = mem_wen_q;
    assign bus.mem_wdata      = mem_wdata_q;
    assign bus.mem_wmask      = mem_wmask_q;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Brief    : Directed self-checking bench for mem_arbiter (TIMEOUT = 4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32), .MASK_W(8)) bus ();

    mem_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .MASK_W  (8),
        .TIMEOUT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.ifu_req_valid  = 1'b0;
        bus.ifu_addr       = '0;
        bus.lsu_req_valid  = 1'b0;
        bus.lsu_addr       = '0;
        bus.lsu_wen        = 1'b0;
        bus.lsu_wdata      = '0;
        bus.lsu_wmask      = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;

        // ---------------- reset state ----------------
        tick(); tick();
        check("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
        check("rst_mem_addr",      bus.mem_addr,           32'd0);
        check("rst_ifu_resp",      32'(bus.ifu_resp_valid), 32'd0);
        check("rst_lsu_resp",      32'(bus.lsu_resp_valid), 32'd0);
        rst_n = 1'b1;
        tick();

        // ---------------- IFU-only read ----------------
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_0000;
        #1;
        check("t1_ifu_ready", 32'(bus.ifu_req_ready), 32'd1);
        check("t1_lsu_ready", 32'(bus.lsu_req_ready), 32'd0);
        tick();                                  // REQ
        bus.ifu_req_valid = 1'b0;
        check("t1_mem_req_valid", 32'(bus.mem_req_valid), 32'd1);
        check("t1_mem_addr",      bus.mem_addr,            32'h8000_0000);
        check("t1_mem_wen",       32'(bus.mem_wen),        32'd0);
        check("t1_mem_wmask",     32'(bus.mem_wmask),      32'd0);
        bus.mem_req_ready = 1'b1;
        tick();                                  // WAIT
        bus.mem_req_ready = 1'b0;
        check("t1_req_dropped", 32'(bus.mem_req_valid), 32'd0);
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h0010_0073;
        tick();                                  // RESP, 3 cycles after handshake
        bus.mem_resp_valid = 1'b0;
        check("t1_ifu_resp_valid", 32'(bus.ifu_resp_valid), 32'd1);
        check("t1_ifu_rdata",      bus.ifu_rdata,           32'h0010_0073);
        check("t1_ifu_err",        32'(bus.ifu_resp_err),   32'd0);
        check("t1_lsu_resp_valid", 32'(bus.lsu_resp_valid), 32'd0);
        tick();                                  // IDLE
        check("t1_ifu_resp_once", 32'(bus.ifu_resp_valid), 32'd0);

        // ---------------- simultaneous requests ----------------
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_0004;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 32'h8000_1000;
        bus.lsu_wen       = 1'b0;
        #1;
        check("t2_lsu_ready_first", 32'(bus.lsu_req_ready), 32'd1);
        check("t2_ifu_not_ready",   32'(bus.ifu_req_ready), 32'd0);
        tick();                                  // REQ (LSU)
        bus.lsu_req_valid = 1'b0;
        check("t2_mem_addr_lsu",   bus.mem_addr,            32'h8000_1000);
        check("t2_ifu_ready_req",  32'(bus.ifu_req_ready),  32'd0);
        bus.mem_req_ready = 1'b1;
        tick();                                  // WAIT
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'hDEAD_BEEF;
        tick();                                  // RESP
        bus.mem_resp_valid = 1'b0;
        check("t2_lsu_resp_valid", 32'(bus.lsu_resp_valid), 32'd1);
        check("t2_lsu_rdata",      bus.lsu_rdata,           32'hDEAD_BEEF);
        check("t2_ifu_resp_quiet", 32'(bus.ifu_resp_valid), 32'd0);
        check("t2_no_accept_resp", 32'(bus.ifu_req_ready),  32'd0);
        tick();                                  // IDLE, IFU now granted
        check("t2_ifu_ready_idle", 32'(bus.ifu_req_ready),  32'd1);
        check("t2_lsu_resp_once",  32'(bus.lsu_resp_valid), 32'd0);
        tick();                                  // REQ (IFU)
        bus.ifu_req_valid = 1'b0;
        check("t2_mem_addr_ifu", bus.mem_addr, 32'h8000_0004);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h0000_0013;
        tick();                                  // RESP (IFU)
        bus.mem_resp_valid = 1'b0;
        check("t2_ifu_resp_valid", 32'(bus.ifu_resp_valid), 32'd1);
        check("t2_ifu_rdata",      bus.ifu_rdata,           32'h0000_0013);
        check("t2_lsu_quiet2",     32'(bus.lsu_resp_valid), 32'd0);
        tick();                                  // IDLE

        // ---------------- LSU write with back-pressure ----------------
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 32'h8000_2003;
        bus.lsu_wen       = 1'b1;
        bus.lsu_wdata     = 32'h0000_00AB;
        bus.lsu_wmask     = 8'h08;
        #1;
        check("t3_lsu_ready", 32'(bus.lsu_req_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.lsu_req_valid = 1'b0;
            check("t3_hold_valid", 32'(bus.mem_req_valid), 32'd1);
            check("t3_hold_addr",  bus.mem_addr,           32'h8000_2003);
            check("t3_hold_wen",   32'(bus.mem_wen),       32'd1);
            check("t3_hold_wdata", bus.mem_wdata,          32'h0000_00AB);
            check("t3_hold_wmask", 32'(bus.mem_wmask),     32'h08);
        end
        bus.mem_req_ready = 1'b1;
        tick();                                  // WAIT
        bus.mem_req_ready  = 1'b0;
        bus.lsu_wen        = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h1234_5678;
        tick();                                  // RESP
        bus.mem_resp_valid = 1'b0;
        check("t3_lsu_resp_valid", 32'(bus.lsu_resp_valid), 32'd1);
        check("t3_lsu_rdata_zero", bus.lsu_rdata,           32'd0);
        check("t3_lsu_err",        32'(bus.lsu_resp_err),   32'd0);
        tick();                                  // IDLE

        // ---------------- timeout ----------------
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 32'h8000_3000;
        bus.lsu_wen       = 1'b0;
        bus.mem_rdata     = 32'hCAFE_F00D;
        tick();                                  // REQ
        bus.lsu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();                                  // WAIT cnt=0
        bus.mem_req_ready = 1'b0;
        tick();                                  // cnt=1
        tick();                                  // cnt=2
        tick();                                  // cnt=3
        check("t4_no_early_resp", 32'(bus.lsu_resp_valid), 32'd0);
        tick();                                  // RESP
        check("t4_lsu_resp_valid", 32'(bus.lsu_resp_valid), 32'd1);
        check("t4_lsu_err",        32'(bus.lsu_resp_err),   32'd1);
        check("t4_lsu_rdata",      bus.lsu_rdata,           32'd0);
        bus.mem_resp_valid = 1'b1;               // late response, must be ignored
        tick();                                  // IDLE
        check("t4_idle_no_req", 32'(bus.mem_req_valid), 32'd0);
        tick();
        bus.mem_resp_valid = 1'b0;
        check("t4_late_ignored_lsu", 32'(bus.lsu_resp_valid), 32'd0);
        check("t4_late_ignored_ifu", 32'(bus.ifu_resp_valid), 32'd0);

        // ---------------- response coinciding with timeout ----------------
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_0008;
        tick();                                  // REQ
        bus.ifu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();                                  // WAIT cnt=0
        bus.mem_req_ready = 1'b0;
        tick();                                  // cnt=1
        tick();                                  // cnt=2
        tick();                                  // cnt=3, final cycle
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h0BAD_F00D;
        tick();                                  // RESP
        bus.mem_resp_valid = 1'b0;
        check("t5_ifu_resp_valid", 32'(bus.ifu_resp_valid), 32'd1);
        check("t5_ifu_err",        32'(bus.ifu_resp_err),   32'd0);
        check("t5_ifu_rdata",      bus.ifu_rdata,           32'h0BAD_F00D);
        tick();                                  // IDLE

        // ---------------- reset mid-WAIT ----------------
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_000C;
        tick();                                  // REQ
        bus.ifu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();                                  // WAIT
        bus.mem_req_ready = 1'b0;
        tick();                                  // still WAIT
        check("t6_pre_rst_addr", bus.mem_addr, 32'h8000_000C);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_addr",      bus.mem_addr,            32'd0);
        check("t6_async_req_valid", 32'(bus.mem_req_valid),  32'd0);
        check("t6_async_ifu_resp",  32'(bus.ifu_resp_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        bus.mem_resp_valid = 1'b1;               // stale response in IDLE
        bus.mem_rdata      = 32'hFFFF_FFFF;
        tick();
        bus.mem_resp_valid = 1'b0;
        check("t6_no_stale_ifu", 32'(bus.ifu_resp_valid), 32'd0);
        check("t6_no_stale_lsu", 32'(bus.lsu_resp_valid), 32'd0);
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_0010;
        #1;
        check("t6_ifu_ready", 32'(bus.ifu_req_ready), 32'd1);
        tick();                                  // REQ
        bus.ifu_req_valid = 1'b0;
        check("t6_mem_addr", bus.mem_addr, 32'h8000_0010);
        bus.mem_req_ready = 1'b1;
        tick();                                  // WAIT
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h1111_2222;
        tick();                                  // RESP
        bus.mem_resp_valid = 1'b0;
        check("t6_ifu_resp_valid", 32'(bus.ifu_resp_valid), 32'd1);
        check("t6_ifu_rdata",      bus.ifu_rdata,           32'h1111_2222);
        check("t6_lsu_quiet",      32'(bus.lsu_resp_valid), 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
